// File: rtl/mem_arbiter.sv
// Round-robin arbiter that puts instruction fetch (I) and load/store (D) requests
// in front of the byte-serial memory controller and returns each result to the requester that issued it.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter bit D_FIRST = 1'b1
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              i_valid,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic              i_ready,
   output logic [31:0]       i_res,
   input  logic              d_valid,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [2:0]        d_len,
   input  logic [31:0]       d_data,
   output logic              d_ready,
   output logic [31:0]       d_res,
   output logic              mc_valid,
   output logic              mc_wr,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [2:0]        mc_len,
   output logic [31:0]       mc_data,
   input  logic              mc_ready,
   input  logic [31:0]       mc_res
);

   // state  | meaning
   // IDLE   | no transaction open; arbitrate between eligible requesters
   // BUSY_I | fetch presented to controller, waiting for mc_ready
   // BUSY_D | load/store presented to controller, waiting for mc_ready
   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   // last_grant: 1 = D was granted most recently, 0 = I
   localparam logic LAST_GRANT_RST = ~D_FIRST;

   state_t state;
   logic   last_grant;
   logic   drop;
   logic   i_elig;
   logic   d_elig;
   logic   grant_i;
   logic   grant_d;

   assign i_elig  = i_valid & ~i_flush;
   assign d_elig  = d_valid;
   assign grant_d = d_elig & (~i_elig | ~last_grant);
   assign grant_i = i_elig & ~grant_d;

   assign i_ready = mc_ready & (state == BUSY_I) & ~drop & ~i_flush & rdy_in;
   assign d_ready = mc_ready & (state == BUSY_D) & rdy_in;
   assign i_res   = i_ready ? mc_res : 32'd0;
   assign d_res   = d_ready ? mc_res : 32'd0;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= IDLE;
         mc_valid   <= 1'b0;
         mc_wr      <= 1'b0;
         mc_addr    <= '0;
         mc_len     <= 3'd0;
         mc_data    <= 32'd0;
         drop       <= 1'b0;
         last_grant <= LAST_GRANT_RST;
      end else if (rdy_in) begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  mc_wr      <= d_wr;
                  mc_addr    <= d_addr;
                  mc_len     <= d_len;
                  mc_data    <= d_data;
                  last_grant <= 1'b1;
                  drop       <= 1'b0;
                  mc_valid   <= 1'b1;
                  state      <= BUSY_D;
               end else if (grant_i) begin
                  mc_wr      <= 1'b0;
                  mc_addr    <= i_addr;
                  mc_len     <= 3'b010;
                  mc_data    <= 32'd0;
                  last_grant <= 1'b0;
                  drop       <= 1'b0;
                  mc_valid   <= 1'b1;
                  state      <= BUSY_I;
               end
            end
            BUSY_I: begin
               // a flushed fetch still runs to completion; only its response is suppressed
               if (i_flush) drop <= 1'b1;
               if (mc_ready) begin
                  mc_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            BUSY_D: begin
               if (mc_ready) begin
                  mc_valid <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               mc_valid <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, contention, store latching,
// flush, pause and async reset, each with hand-computed expectations.
module tb_mem_arbiter;
   localparam int ADDR_W = 32;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              rdy_in;
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_flush;
   logic              i_ready;
   logic [31:0]       i_res;
   logic              d_valid;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [2:0]        d_len;
   logic [31:0]       d_data;
   logic              d_ready;
   logic [31:0]       d_res;
   logic              mc_valid;
   logic              mc_wr;
   logic [ADDR_W-1:0] mc_addr;
   logic [2:0]        mc_len;
   logic [31:0]       mc_data;
   logic              mc_ready;
   logic [31:0]       mc_res;

   int n_cmp = 0;
   int n_bad = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .D_FIRST(1'b1)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
      .i_valid(i_valid), .i_addr(i_addr), .i_flush(i_flush),
      .i_ready(i_ready), .i_res(i_res),
      .d_valid(d_valid), .d_wr(d_wr), .d_addr(d_addr), .d_len(d_len),
      .d_data(d_data), .d_ready(d_ready), .d_res(d_res),
      .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
      .mc_data(mc_data), .mc_ready(mc_ready), .mc_res(mc_res)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic apply_reset();
      rst_n_in = 1'b0;
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; rdy_in = 1'b1;
      i_valid = 0; i_addr = '0; i_flush = 0;
      d_valid = 0; d_wr = 0; d_addr = '0; d_len = 3'd0; d_data = 32'd0;
      mc_ready = 1'b1; mc_res = 32'hA5A5A5A5;
      #2;
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mc_valid got %0h exp 0", mc_valid); end
      n_cmp++; if ({mc_wr, mc_len, mc_addr, mc_data} !== '0) begin n_bad++; $display("FAIL rst_mc_fields got %0h/%0h/%0h/%0h exp 0", mc_wr, mc_len, mc_addr, mc_data); end
      n_cmp++; if ({i_ready, d_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_readies got %b exp 00", {i_ready, d_ready}); end
      n_cmp++; if ({i_res, d_res} !== 64'd0) begin n_bad++; $display("FAIL rst_res got %0h exp 0", {i_res, d_res}); end
      mc_ready = 1'b0;
      @(posedge clk_in);
      #3;
      rst_n_in = 1'b1;
      tick();
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_idle_valid got %0h exp 0", mc_valid); end
   endtask

   task automatic test_i_only();
      i_valid = 1'b1; i_addr = 32'h100;
      tick();
      n_cmp++; if (mc_valid !== 1'b1) begin n_bad++; $display("FAIL ionly_mc_valid got %0h exp 1", mc_valid); end
      n_cmp++; if (mc_addr !== 32'h100) begin n_bad++; $display("FAIL ionly_mc_addr got %0h exp 100", mc_addr); end
      n_cmp++; if ({mc_wr, mc_len} !== 4'b0010) begin n_bad++; $display("FAIL ionly_wr_len got %b exp 0010", {mc_wr, mc_len}); end
      n_cmp++; if (mc_data !== 32'd0) begin n_bad++; $display("FAIL ionly_mc_data got %0h exp 0", mc_data); end
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({i_ready, d_ready, mc_valid} !== 3'b001) begin n_bad++; $display("FAIL ionly_wait%0d got %b exp 001", k, {i_ready, d_ready, mc_valid}); end
         tick();
      end
      mc_ready = 1'b1; mc_res = 32'hDEADBEEF;
      #1;
      n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL ionly_i_ready got %0h exp 1", i_ready); end
      n_cmp++; if (i_res !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ionly_i_res got %0h exp deadbeef", i_res); end
      n_cmp++; if ({d_ready, d_res} !== 33'd0) begin n_bad++; $display("FAIL ionly_d_side got %0h exp 0", {d_ready, d_res}); end
      tick();
      mc_ready = 1'b0; i_valid = 1'b0;
      #1;
      n_cmp++; if ({mc_valid, i_ready} !== 2'b00) begin n_bad++; $display("FAIL ionly_done got %b exp 00", {mc_valid, i_ready}); end
   endtask

   task automatic test_contention();
      logic exp_d;
      apply_reset();
      i_valid = 1'b1; i_addr = 32'h40;
      d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h80; d_len = 3'b010; d_data = 32'd0;
      exp_d = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++; if (mc_valid !== 1'b1) begin n_bad++; $display("FAIL cont%0d_valid got %0h exp 1", k, mc_valid); end
         n_cmp++; if (mc_addr !== (exp_d ? 32'h80 : 32'h40)) begin n_bad++; $display("FAIL cont%0d_addr got %0h exp %0h", k, mc_addr, exp_d ? 32'h80 : 32'h40); end
         mc_ready = 1'b1; mc_res = 32'h1000 + k;
         #1;
         n_cmp++; if ({d_ready, i_ready} !== {exp_d, ~exp_d}) begin n_bad++; $display("FAIL cont%0d_ready got %b exp %b", k, {d_ready, i_ready}, {exp_d, ~exp_d}); end
         tick();
         mc_ready = 1'b0;
         exp_d = ~exp_d;
      end
      i_valid = 1'b0; d_valid = 1'b0;
      #1;
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL cont_idle got %0h exp 0", mc_valid); end
   endtask

   task automatic test_store_latch();
      d_valid = 1'b1; d_wr = 1'b1; d_addr = 32'h2000; d_len = 3'b001; d_data = 32'h1234;
      tick();
      n_cmp++; if ({mc_valid, mc_wr, mc_len} !== 5'b11001) begin n_bad++; $display("FAIL st_ctl got %b exp 11001", {mc_valid, mc_wr, mc_len}); end
      n_cmp++; if (mc_addr !== 32'h2000) begin n_bad++; $display("FAIL st_addr got %0h exp 2000", mc_addr); end
      n_cmp++; if (mc_data !== 32'h1234) begin n_bad++; $display("FAIL st_data got %0h exp 1234", mc_data); end
      d_data = 32'hFFFF; d_addr = 32'h3000; d_wr = 1'b0;
      tick();
      tick();
      n_cmp++; if ({mc_data, mc_addr, mc_wr} !== {32'h1234, 32'h2000, 1'b1}) begin n_bad++; $display("FAIL st_hold got %0h/%0h/%0h exp 1234/2000/1", mc_data, mc_addr, mc_wr); end
      mc_ready = 1'b1; mc_res = 32'h0;
      #1;
      n_cmp++; if ({d_ready, i_ready} !== 2'b10) begin n_bad++; $display("FAIL st_ready got %b exp 10", {d_ready, i_ready}); end
      tick();
      mc_ready = 1'b0; d_valid = 1'b0;
      #1;
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL st_done got %0h exp 0", mc_valid); end
   endtask

   task automatic test_flush();
      i_valid = 1'b1; i_addr = 32'h300;
      tick();
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL fl_grant got %0h/%0h exp 1/300", mc_valid, mc_addr); end
      tick();
      i_flush = 1'b1;
      d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h500; d_len = 3'b110; d_data = 32'd0;
      tick();
      i_flush = 1'b0; i_valid = 1'b0;
      #1;
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h300}) begin n_bad++; $display("FAIL fl_hold got %0h/%0h exp 1/300", mc_valid, mc_addr); end
      tick();
      mc_ready = 1'b1; mc_res = 32'h55;
      #1;
      n_cmp++; if ({i_ready, i_res} !== 33'd0) begin n_bad++; $display("FAIL fl_no_iready got %0h/%0h exp 0/0", i_ready, i_res); end
      n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL fl_no_dready got %0h exp 0", d_ready); end
      tick();
      mc_ready = 1'b0;
      #1;
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL fl_turnaround got %0h exp 0", mc_valid); end
      tick();
      n_cmp++; if ({mc_valid, mc_addr, mc_len} !== {1'b1, 32'h500, 3'b110}) begin n_bad++; $display("FAIL fl_d_grant got %0h/%0h/%0h exp 1/500/6", mc_valid, mc_addr, mc_len); end
      mc_ready = 1'b1; mc_res = 32'hFFFFFF80;
      #1;
      n_cmp++; if ({d_ready, d_res} !== {1'b1, 32'hFFFFFF80}) begin n_bad++; $display("FAIL fl_d_done got %0h/%0h exp 1/ffffff80", d_ready, d_res); end
      tick();
      mc_ready = 1'b0; d_valid = 1'b0;
      // flush in IDLE blocks granting the fetch for that cycle
      i_valid = 1'b1; i_flush = 1'b1; i_addr = 32'h340;
      tick();
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL fl_idle_block got %0h exp 0", mc_valid); end
      i_flush = 1'b0;
      tick();
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h340}) begin n_bad++; $display("FAIL fl_regrant got %0h/%0h exp 1/340", mc_valid, mc_addr); end
      mc_ready = 1'b1; mc_res = 32'h77;
      #1;
      n_cmp++; if ({i_ready, i_res} !== {1'b1, 32'h77}) begin n_bad++; $display("FAIL fl_drop_clear got %0h/%0h exp 1/77", i_ready, i_res); end
      tick();
      mc_ready = 1'b0; i_valid = 1'b0;
   endtask

   task automatic test_pause();
      d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h600; d_len = 3'b010;
      tick();
      rdy_in = 1'b0; mc_ready = 1'b1; mc_res = 32'hCAFE;
      for (int j = 0; j < 3; j++) begin
         #1;
         n_cmp++; if ({d_ready, d_res} !== 33'd0) begin n_bad++; $display("FAIL pause%0d_dready got %0h/%0h exp 0/0", j, d_ready, d_res); end
         n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h600}) begin n_bad++; $display("FAIL pause%0d_state got %0h/%0h exp 1/600", j, mc_valid, mc_addr); end
         tick();
      end
      rdy_in = 1'b1;
      #1;
      n_cmp++; if ({d_ready, d_res} !== {1'b1, 32'hCAFE}) begin n_bad++; $display("FAIL pause_resume got %0h/%0h exp 1/cafe", d_ready, d_res); end
      tick();
      mc_ready = 1'b0; d_valid = 1'b0;
      #1;
      n_cmp++; if (mc_valid !== 1'b0) begin n_bad++; $display("FAIL pause_done got %0h exp 0", mc_valid); end
   endtask

   task automatic test_async_reset();
      i_valid = 1'b1; i_addr = 32'h700;
      tick();
      n_cmp++; if (mc_valid !== 1'b1) begin n_bad++; $display("FAIL ar_busy got %0h exp 1", mc_valid); end
      #3;
      rst_n_in = 1'b0;
      #1;
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL ar_immediate got %0h/%0h exp 0/0", mc_valid, mc_addr); end
      mc_ready = 1'b1;
      #1;
      n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL ar_no_iready got %0h exp 0", i_ready); end
      #2;
      rst_n_in = 1'b1; mc_ready = 1'b0;
      d_valid = 1'b1; d_wr = 1'b0; d_addr = 32'h900; d_len = 3'b000;
      tick();
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h900}) begin n_bad++; $display("FAIL ar_d_first got %0h/%0h exp 1/900", mc_valid, mc_addr); end
      mc_ready = 1'b1;
      tick();
      mc_ready = 1'b0; d_valid = 1'b0;
      tick();
      n_cmp++; if ({mc_valid, mc_addr} !== {1'b1, 32'h700}) begin n_bad++; $display("FAIL ar_then_i got %0h/%0h exp 1/700", mc_valid, mc_addr); end
      i_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_i_only();
      test_contention();
      test_store_latch();
      test_flush();
      test_pause();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
